// File: rtl/uart_tx_fifo_if.sv
// Handshake bundle between the byte producer, the TX FIFO and the UART transmitter.
// master = producer/transmitter side, slave = the FIFO itself.
interface uart_tx_fifo_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic [DATA_W-1:0] wr_data;
  logic              wr_en;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              busy;

  modport master (
    output wr_data, wr_en, tx_ready,
    input  full, empty, count, overflow, tx_data, tx_valid, busy
  );

  modport slave (
    input  wr_data, wr_en, tx_ready,
    output full, empty, count, overflow, tx_data, tx_valid, busy
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter; issues one byte per frame over the
// tx_valid/tx_ready handshake and waits for the frame to finish before the next.
module uart_tx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input logic           clk,
  input logic           rst,
  uart_tx_fifo_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DONE} state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  state_t            state, state_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count_q, count_nxt;
  logic              full_q, empty_q, overflow_q;
  logic [DATA_W-1:0] tx_data_p0;
  logic              vld_p0, vld_nxt;
  logic              push, pop;

  // full is the pre-edge flag, so a write to a full FIFO is refused even if a pop coincides
  assign push = bus.wr_en && !full_q;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    vld_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty_q && bus.tx_ready) begin
          pop       = 1'b1;
          vld_nxt   = 1'b1;
          state_nxt = WAIT_ACK;
        end
      end
      // tx_ready lags acceptance by one cycle, so the pulse cycle itself never exits here
      WAIT_ACK:  if (!bus.tx_ready) state_nxt = WAIT_DONE;
      WAIT_DONE: if (bus.tx_ready)  state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    count_nxt = count_q;
    if (push && !pop)      count_nxt = count_q + (ADDR_W+1)'(1);
    else if (!push && pop) count_nxt = count_q - (ADDR_W+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      vld_p0     <= 1'b0;
      tx_data_p0 <= '0;
    end else begin
      state      <= state_nxt;
      count_q    <= count_nxt;
      full_q     <= (count_nxt == DEPTH_C);
      empty_q    <= (count_nxt == '0);
      overflow_q <= bus.wr_en && full_q;
      vld_p0     <= vld_nxt;
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop) begin
        rd_ptr     <= rd_ptr + ADDR_W'(1);
        tx_data_p0 <= mem[rd_ptr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.wr_data;
  end

  assign bus.full     = full_q;
  assign bus.empty    = empty_q;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
  assign bus.tx_data  = tx_data_p0;
  assign bus.tx_valid = vld_p0;
  assign bus.busy     = (state != IDLE) || (count_q != '0);
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo with a behavioural transmitter handshake model.
module tb_uart_tx_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_tx_fifo_if #(.DATA_W(8), .ADDR_W(4)) bus ();

  uart_tx_fifo #(.DATA_W(8), .DEPTH(16), .ADDR_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] sb[$];
  bit         hold = 1'b0;
  int         frame_len = 4;
  bit         frame_active = 1'b0;
  bit         lag = 1'b0;
  int         frame_cnt = 0;
  bit         prev_valid = 1'b0;
  int         n_issued = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Transmitter model: ready stays high during the pulse cycle, drops the next,
  // stays low for frame_len cycles, then returns high.
  initial begin
    logic [7:0] exp_b;
    bus.tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        frame_active = 1'b0;
        lag          = 1'b0;
        frame_cnt    = 0;
        prev_valid   = 1'b0;
        bus.tx_ready = !hold;
      end else begin
        if (bus.tx_valid) begin
          n_issued++;
          check("pulse_len", 32'(prev_valid), 0);
          check("no_overlap", 32'(frame_active), 0);
          check("ready_at_issue", 32'(bus.tx_ready), 1);
          check("sb_nonempty", 32'(sb.size() > 0), 1);
          if (sb.size() > 0) begin
            exp_b = sb.pop_front();
            check("tx_data", 32'(bus.tx_data), 32'(exp_b));
          end
          frame_active = 1'b1;
          lag          = 1'b1;
        end else if (frame_active) begin
          if (lag) begin
            lag          = 1'b0;
            bus.tx_ready = 1'b0;
            frame_cnt    = frame_len;
          end else if (frame_cnt > 1) begin
            frame_cnt--;
          end else begin
            frame_active = 1'b0;
            bus.tx_ready = !hold;
          end
        end else begin
          bus.tx_ready = !hold;
        end
        prev_valid = bus.tx_valid;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b, input bit accept);
    bus.wr_en   = 1'b1;
    bus.wr_data = b;
    if (accept) sb.push_back(b);
    step();
    bus.wr_en = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || frame_active) && n < 3000) begin
      step();
      n++;
    end
    check("drain_done", 32'(n < 3000), 1);
    step();
    step();
    check("empty_after", 32'(bus.empty), 1);
    check("busy_after", 32'(bus.busy), 0);
    check("count_after", 32'(bus.count), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    rst = 1'b1;
    repeat (3) step();
    check("rst_count", 32'(bus.count), 0);
    check("rst_empty", 32'(bus.empty), 1);
    check("rst_full", 32'(bus.full), 0);
    check("rst_overflow", 32'(bus.overflow), 0);
    check("rst_tx_valid", 32'(bus.tx_valid), 0);
    check("rst_tx_data", 32'(bus.tx_data), 0);
    check("rst_busy", 32'(bus.busy), 0);
    rst = 1'b0;
    step();

    // single byte, two-cycle latency
    push_byte(8'hA5, 1'b1);
    check("lat_valid_n1", 32'(bus.tx_valid), 0);
    check("lat_count_n1", 32'(bus.count), 1);
    step();
    check("lat_valid_n2", 32'(bus.tx_valid), 1);
    check("lat_data_n2", 32'(bus.tx_data), 32'hA5);
    check("lat_count_n2", 32'(bus.count), 0);
    wait_drain();

    // burst to full with the transmitter held off, then overflow
    hold = 1'b1;
    step();
    step();
    for (int i = 0; i < 16; i++) begin
      push_byte(8'(i + 1), 1'b1);
      check("burst_count", 32'(bus.count), 32'(i + 1));
      check("burst_full", 32'(bus.full), 32'(i == 15));
    end
    push_byte(8'hFF, 1'b0);
    check("ovf_pulse", 32'(bus.overflow), 1);
    check("ovf_count", 32'(bus.count), 16);
    check("ovf_full", 32'(bus.full), 1);
    step();
    check("ovf_clear", 32'(bus.overflow), 0);
    check("ovf_no_issue", 32'(bus.tx_valid), 0);
    hold = 1'b0;
    wait_drain();

    // simultaneous push and issue keeps count
    hold = 1'b1;
    step();
    step();
    for (int i = 0; i < 3; i++) push_byte(8'h30 + 8'(i), 1'b1);
    check("pp_count_pre", 32'(bus.count), 3);
    hold = 1'b0;
    push_byte(8'h5A, 1'b1);
    check("pp_issue", 32'(bus.tx_valid), 1);
    check("pp_count", 32'(bus.count), 3);
    wait_drain();

    // pointer wrap: 40 bytes through in four bursts
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 10; i++) push_byte(8'($urandom_range(0, 255)), 1'b1);
      wait_drain();
    end

    // long frames: one issue per frame, none while ready is low
    frame_len = 50;
    base = n_issued;
    push_byte(8'hC1, 1'b1);
    push_byte(8'hC2, 1'b1);
    push_byte(8'hC3, 1'b1);
    wait_drain();
    check("long_issue_cnt", 32'(n_issued - base), 3);

    // reset mid-frame discards queued bytes
    frame_len = 20;
    for (int i = 0; i < 5; i++) push_byte(8'hE0 + 8'(i), 1'b1);
    repeat (8) step();
    check("mid_busy", 32'(bus.busy), 1);
    rst = 1'b1;
    sb.delete();
    step();
    check("mrst_count", 32'(bus.count), 0);
    check("mrst_empty", 32'(bus.empty), 1);
    check("mrst_tx_valid", 32'(bus.tx_valid), 0);
    check("mrst_busy", 32'(bus.busy), 0);
    rst = 1'b0;
    base = n_issued;
    repeat (30) step();
    check("mrst_no_issue", 32'(n_issued - base), 0);
    frame_len = 4;
    push_byte(8'h3C, 1'b1);
    wait_drain();
    check("mrst_new_issue", 32'(n_issued - base), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
